// File: rtl/fibo_sched_pkg.sv
// rtl/fibo_sched_pkg.sv - shared defaults, context type and id-width helper for the Fibonacci stream scheduler
package fibo_sched_pkg;

  localparam int NREQ_DEF   = 4;
  localparam int W_DEF      = 8;
  localparam int SEED_A_DEF = 0;
  localparam int SEED_B_DEF = 1;

  typedef struct packed {
    logic [W_DEF-1:0] a;
    logic [W_DEF-1:0] b;
  } fibo_ctx_t;

  // A single requester still needs a one-bit id field.
  function automatic int id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with registered last-grant pointer, priority starts after last winner
module rr_arbiter
  import fibo_sched_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = id_width(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [N-1:0]  elig,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] last_q, last_d;
  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    grant  = '0;
    idx    = '0;
    cand   = '0;
    found  = 1'b0;
    last_d = last_q;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(last_q) + k) % N);
      if (!found && elig[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    if (en && found) begin
      grant[idx] = 1'b1;
      last_d     = idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= IW'(N - 1);
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/fibo_stream_scheduler.sv
// rtl/fibo_stream_scheduler.sv - per-requester Fibonacci contexts sharing one adder behind a round-robin valid/ready output
module fibo_stream_scheduler
  import fibo_sched_pkg::*;
#(
  parameter  int          NREQ   = NREQ_DEF,
  parameter  int          W      = W_DEF,
  parameter  int unsigned SEED_A = SEED_A_DEF,
  parameter  int unsigned SEED_B = SEED_B_DEF,
  localparam int          IW     = id_width(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] clr,
  output logic [NREQ-1:0] grant,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_data,
  output logic [IW-1:0]   out_id
);

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
  } ctx_t;

  localparam ctx_t CTX_SEED = '{a: W'(SEED_A), b: W'(SEED_B)};

  ctx_t            ctx_q [NREQ];
  ctx_t            ctx_d [NREQ];
  logic            out_valid_q, out_valid_d;
  logic [W-1:0]    out_data_q, out_data_d;
  logic [IW-1:0]   out_id_q, out_id_d;

  logic            load;
  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] arb_grant;
  logic [IW-1:0]   win;
  logic [W-1:0]    sum;

  // out_ready reaches only the load decision and grant, never the output registers' data path.
  assign load = !out_valid_q || out_ready;
  assign elig = req & ~clr;

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .en    (load),
    .elig  (elig),
    .grant (arb_grant),
    .idx   (win)
  );

  assign grant = arb_grant;
  assign sum   = ctx_q[win].a + ctx_q[win].b;

  always_comb begin
    ctx_d       = ctx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    if (load) begin
      if (|arb_grant) begin
        out_valid_d    = 1'b1;
        out_data_d     = ctx_q[win].a;
        out_id_d       = win;
        ctx_d[win].a   = ctx_q[win].b;
        ctx_d[win].b   = sum;
      end else begin
        out_valid_d = 1'b0;
      end
    end
    // A cleared requester is excluded from elig, so clear never collides with an advance.
    for (int i = 0; i < NREQ; i++) begin
      if (clr[i]) begin
        ctx_d[i] = CTX_SEED;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) begin
        ctx_q[i] <= CTX_SEED;
      end
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
    end else begin
      ctx_q       <= ctx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;

endmodule
